inst_encoder: RTL

// Inverse of the CPU's decode stage: packs instruction fields (format, opcode, funct3/7, rd, rs1, rs2, imm32)

---
 rtl/inst_encoder_if.sv | 28 ++
 rtl/inst_encoder.sv | 108 ++++++++++
 2 files changed

// File: rtl/inst_encoder_if.sv
// Field-bundle input and encoded-word output handshakes of inst_encoder.
// The master side supplies instruction fields and consumes words; the slave side is the encoder.
interface inst_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  fmt;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic        out_err;

   modport master (
      output in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm, out_ready,
      input  in_ready, out_valid, out_inst, out_err
   );

   modport slave (
      input  in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm, out_ready,
      output in_ready, out_valid, out_inst, out_err
   );
endinterface

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs instruction fields into a word and queues it in a DEPTH-entry FIFO.
// Define RANGE_CHECK_EN to flag immediates that the chosen format cannot represent.
module inst_encoder #(
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   inst_encoder_if.slave bus,
   input  logic          clr_cnt,
   output logic [15:0]   inst_count,
   output logic [15:0]   err_count
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   typedef struct packed {
      logic [31:0] inst;
      logic        err;
   } entry_t;

   entry_t        enc;
   entry_t        mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          push;
   logic          pop;
   logic [31:0]   imm;

   assign imm = bus.imm;

   // NOTE: defaults assigned first so every path drives enc and no latch is inferred.
   always_comb begin
      enc.inst = 32'h0000_0013;
      enc.err  = 1'b0;
      case (bus.fmt)
         FMT_R: enc.inst = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
         FMT_I: enc.inst = {imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
         FMT_S: enc.inst = {imm[11:5], bus.rs2, bus.rs1, bus.funct3, imm[4:0], bus.opcode};
         FMT_B: enc.inst = {imm[12], imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                            imm[4:1], imm[11], bus.opcode};
         FMT_U: enc.inst = {imm[31:12], bus.rd, bus.opcode};
         FMT_J: enc.inst = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd, bus.opcode};
         default: enc.err = 1'b1;
      endcase
`ifdef RANGE_CHECK_EN
      case (bus.fmt)
         FMT_I, FMT_S: enc.err = (imm != {{20{imm[11]}}, imm[11:0]});
         FMT_B:        enc.err = (imm != {{19{imm[12]}}, imm[12:0]}) || imm[0];
         FMT_U:        enc.err = (imm[11:0] != 12'h000);
         FMT_J:        enc.err = (imm != {{11{imm[20]}}, imm[20:0]}) || imm[0];
         default:      ;
      endcase
`endif
   end

   assign bus.in_ready  = (count < FULL);
   assign bus.out_valid = (count != '0);
   assign push          = bus.in_valid && bus.in_ready;
   assign pop           = bus.out_valid && bus.out_ready;

   // NOTE: storage is not reset; the head is masked by out_valid so stale entries never show.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= enc;
   end

   assign bus.out_inst = bus.out_valid ? mem[rd_ptr].inst : 32'h0;
   assign bus.out_err  = bus.out_valid ? mem[rd_ptr].err  : 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // A clear coinciding with an accept leaves the counters holding just that accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_count <= '0;
         err_count  <= '0;
      end else if (clr_cnt) begin
         inst_count <= {15'd0, push};
         err_count  <= {15'd0, push && enc.err};
      end else if (push) begin
         inst_count <= inst_count + 1'b1;
         if (enc.err && err_count != 16'hFFFF) err_count <= err_count + 1'b1;
      end
   end
endmodule
